// File: rtl/route_arb_pkg.sv
// Shared encodings for the router output-stage arbiter.
package route_arb_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_e;

  // Virtual-channel indices.
  localparam logic VC0 = 1'b0;
  localparam logic VC1 = 1'b1;

  // SERVE state that corresponds to a granted VC.
  function automatic arb_state_e serve_state(input logic vc);
    return vc ? SERVE1 : SERVE0;
  endfunction

endpackage

// File: rtl/route_out_arbiter.sv
// Weighted round-robin arbiter draining two VC FIFOs onto one 8-bit link,
// with almost-full urgency preemption and downstream pause.
module route_out_arbiter
  import route_arb_pkg::*;
#(
  parameter int unsigned WEIGHT0 = 4,
  parameter int unsigned WEIGHT1 = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fifo0_empty,
  input  logic              fifo1_empty,
  input  logic              almost_full0,
  input  logic              almost_full1,
  input  logic [DATA_W-1:0] out0,
  input  logic [DATA_W-1:0] out1,
  input  logic              pause_in,
  output logic              read0,
  output logic              read1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              vc_out
);

  localparam logic [CNT_W-1:0] W0      = CNT_W'(WEIGHT0);
  localparam logic [CNT_W-1:0] W1      = CNT_W'(WEIGHT1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic             last_vc_q, last_vc_d;
  logic             valid_out_q, valid_out_d;
  logic             vc_out_q, vc_out_d;

  logic             grant;
  logic             grant_vc;
  logic             own_vc, oth_vc;
  logic             own_ne, oth_ne;
  logic             own_af, oth_af;
  logic [CNT_W-1:0] own_weight;

  // Grant selection and next-state computation.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_vc_d   = last_vc_q;
    grant       = 1'b0;
    grant_vc    = last_vc_q;

    own_vc     = (state_q == SERVE1) ? VC1 : VC0;
    oth_vc     = ~own_vc;
    own_ne     = own_vc ? ~fifo1_empty : ~fifo0_empty;
    oth_ne     = own_vc ? ~fifo0_empty : ~fifo1_empty;
    own_af     = own_vc ? almost_full1 : almost_full0;
    oth_af     = own_vc ? almost_full0 : almost_full1;
    own_weight = own_vc ? W1 : W0;

    if (!pause_in) begin
      case (state_q)
        SERVE0, SERVE1: begin
          if (oth_ne && oth_af && !own_af) begin
            grant       = 1'b1;
            grant_vc    = oth_vc;
            burst_cnt_d = CNT_ONE;
          end else if (own_ne && (burst_cnt_q < own_weight)) begin
            grant       = 1'b1;
            grant_vc    = own_vc;
            burst_cnt_d = burst_cnt_q + CNT_ONE;
          end else if (oth_ne) begin
            grant       = 1'b1;
            grant_vc    = oth_vc;
            burst_cnt_d = CNT_ONE;
          end else if (own_ne) begin
            grant       = 1'b1;
            grant_vc    = own_vc;
            burst_cnt_d = CNT_ONE;
          end else begin
            state_d = IDLE;
          end
        end
        default: begin
          // Idle: tie goes to the VC not served last.
          if (!fifo0_empty && !fifo1_empty) begin
            grant    = 1'b1;
            grant_vc = ~last_vc_q;
          end else if (!fifo0_empty) begin
            grant    = 1'b1;
            grant_vc = VC0;
          end else if (!fifo1_empty) begin
            grant    = 1'b1;
            grant_vc = VC1;
          end
          if (grant) begin
            burst_cnt_d = CNT_ONE;
          end
        end
      endcase

      if (grant) begin
        state_d   = serve_state(grant_vc);
        last_vc_d = grant_vc;
      end
    end

    valid_out_d = grant;
    vc_out_d    = grant ? grant_vc : vc_out_q;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      last_vc_q   <= VC1;
      valid_out_q <= 1'b0;
      vc_out_q    <= VC0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_vc_q   <= last_vc_d;
      valid_out_q <= valid_out_d;
      vc_out_q    <= vc_out_d;
    end
  end

  // Pop strobes are held low while reset is asserted.
  assign read0 = grant & (grant_vc == VC0) & reset;
  assign read1 = grant & (grant_vc == VC1) & reset;

  // Popped word arrives the cycle after the read; steer it by the registered tag.
  assign valid_out = valid_out_q;
  assign vc_out    = vc_out_q;
  assign data_out  = valid_out_q ? (vc_out_q ? out1 : out0) : '0;

endmodule

// File: tb/tb_route_out_arbiter.sv
// Self-checking bench for route_out_arbiter: FIFO queues plus a rule-level
// arbitration model predict every pop strobe and every delivered word.
`timescale 1ns/1ps
module tb_route_out_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo0_empty, fifo1_empty;
  logic       almost_full0, almost_full1;
  logic [7:0] out0, out1;
  logic       pause_in;
  logic       read0, read1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       vc_out;

  route_out_arbiter #(.WEIGHT0(4), .WEIGHT1(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .fifo0_empty  (fifo0_empty),
    .fifo1_empty  (fifo1_empty),
    .almost_full0 (almost_full0),
    .almost_full1 (almost_full1),
    .out0         (out0),
    .out1         (out1),
    .pause_in     (pause_in),
    .read0        (read0),
    .read1        (read1),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .vc_out       (vc_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Bench-side FIFO contents and stimulus knobs.
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       af0 = 1'b0, af1 = 1'b0, pse = 1'b0;
  int         w[2] = '{4, 4};

  // Reference model: which VC is being served (-1 none), burst length, last VC,
  // and the word expected on the link this cycle.
  int         m_serv, m_cnt, m_last;
  logic       m_v, m_vc;
  logic [7:0] m_d;

  // Expected values captured for the cycle just observed.
  logic [1:0] e_g;
  logic       e_v, e_vc;
  logic [7:0] e_d;

  function automatic logic [1:0] model_pick();
    bit ne[2];
    bit af[2];
    int g, own, oth;
    ne[0] = (q0.size() != 0);
    ne[1] = (q1.size() != 0);
    af[0] = af0;
    af[1] = af1;
    g = -1;
    if (reset && !pse) begin
      if (m_serv < 0) begin
        if (ne[0] && ne[1]) g = 1 - m_last;
        else if (ne[0])     g = 0;
        else if (ne[1])     g = 1;
      end else begin
        own = m_serv;
        oth = 1 - own;
        if (ne[oth] && af[oth] && !af[own])   g = oth;
        else if (ne[own] && m_cnt < w[own])   g = own;
        else if (ne[oth])                     g = oth;
        else if (ne[own])                     g = own;
      end
    end
    if (g < 0) return 2'b00;
    return (g == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_reset();
    m_serv = -1; m_cnt = 0; m_last = 1;
    m_v = 1'b0; m_vc = 1'b0; m_d = 8'h00;
  endtask

  // Apply the clock edge's effect: pop the granted FIFO, present its word.
  task automatic model_update(input logic [1:0] g2);
    int g;
    logic [7:0] v;
    out0 = 8'($urandom);
    out1 = 8'($urandom);
    if (g2 == 2'b00) begin
      if (!pse) m_serv = -1;
      m_v = 1'b0;
      m_d = 8'h00;
    end else begin
      g = g2[1] ? 1 : 0;
      if (g == 0) begin v = q0.pop_front(); out0 = v; end
      else        begin v = q1.pop_front(); out1 = v; end
      m_cnt  = (g == m_serv && m_cnt < w[g]) ? m_cnt + 1 : 1;
      m_serv = g;
      m_last = g;
      m_v    = 1'b1;
      m_vc   = g[0];
      m_d    = v;
    end
  endtask

  // One clock cycle: drive inputs, observe, advance the model past the edge.
  task automatic tick(output logic [1:0] og, output logic ov, output logic ovc,
                      output logic [7:0] od);
    fifo0_empty  = (q0.size() == 0);
    fifo1_empty  = (q1.size() == 0);
    almost_full0 = af0;
    almost_full1 = af1;
    pause_in     = pse;
    #2;
    og  = {read1, read0};
    ov  = valid_out;
    ovc = vc_out;
    od  = data_out;
    e_g = model_pick();
    e_v = m_v; e_vc = m_vc; e_d = m_d;
    @(posedge clk);
    #1;
    model_update(e_g);
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) q0.push_back(8'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(8'($urandom));
  endtask

  // Synchronous-looking reset pulse aligned to the bench's drive phase.
  task automatic reset_dut();
    reset = 1'b0;
    pse = 1'b0; af0 = 1'b0; af1 = 1'b0;
    q0.delete(); q1.delete();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    reset = 1'b0;
    model_reset();
    fill(2, 2);
    out0 = 8'h5A; out1 = 8'hA5;
    fifo0_empty = 1'b0; fifo1_empty = 1'b0;
    almost_full0 = 1'b0; almost_full1 = 1'b0; pause_in = 1'b0;
    #2;
    n_checks++;
    if ({read1, read0} !== 2'b00) begin
      n_errors++; $display("FAIL reset_read: read1/read0=%b want 00", {read1, read0});
    end
    n_checks++;
    if (valid_out !== 1'b0 || vc_out !== 1'b0) begin
      n_errors++; $display("FAIL reset_valid: valid=%b vc=%b want 0 0", valid_out, vc_out);
    end
    n_checks++;
    if (data_out !== 8'h00) begin
      n_errors++; $display("FAIL reset_data: data_out=%h want 00", data_out);
    end
    q0.delete(); q1.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(og, ov, ovc, od);
      n_checks++;
      if (og !== 2'b00 || ov !== 1'b0 || od !== 8'h00) begin
        n_errors++;
        $display("FAIL reset_idle cyc %0d: read=%b valid=%b data=%h want 00 0 00", i, og, ov, od);
      end
    end
  endtask

  task automatic test_single_vc();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    logic [1:0] want_g[5] = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [7:0] want_d[5] = '{8'h00, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    logic       want_v[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    q0.push_back(8'hAA); q0.push_back(8'hBB); q0.push_back(8'hCC);
    for (int i = 0; i < 5; i++) begin
      tick(og, ov, ovc, od);
      n_checks++;
      if (og !== want_g[i] || og !== e_g) begin
        n_errors++;
        $display("FAIL single_grant cyc %0d: read=%b want %b (model %b)", i, og, want_g[i], e_g);
      end
      n_checks++;
      if (ov !== want_v[i] || od !== want_d[i] || (want_v[i] && ovc !== 1'b0)) begin
        n_errors++;
        $display("FAIL single_data cyc %0d: valid=%b vc=%b data=%h want %b 0 %h",
                 i, ov, ovc, od, want_v[i], want_d[i]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    logic [1:0] want;
    reset_dut();
    fill(40, 40);
    for (int i = 0; i < 32; i++) begin
      tick(og, ov, ovc, od);
      want = ((i / 4) % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++;
      if (og !== want || og !== e_g) begin
        n_errors++;
        $display("FAIL fair_grant cyc %0d: read=%b want %b (model %b)", i, og, want, e_g);
      end
      n_checks++;
      if (ov !== e_v || od !== e_d || (e_v && ovc !== e_vc)) begin
        n_errors++;
        $display("FAIL fair_data cyc %0d: valid=%b vc=%b data=%h want %b %b %h",
                 i, ov, ovc, od, e_v, e_vc, e_d);
      end
    end
  endtask

  task automatic test_pause();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    logic [1:0] want_g[10] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                               2'b01, 2'b01, 2'b10};
    reset_dut();
    fill(20, 20);
    for (int i = 0; i < 10; i++) begin
      pse = (i >= 2 && i < 7);
      tick(og, ov, ovc, od);
      n_checks++;
      if (og !== want_g[i] || og !== e_g) begin
        n_errors++;
        $display("FAIL pause_grant cyc %0d: read=%b want %b (model %b)", i, og, want_g[i], e_g);
      end
      n_checks++;
      if (ov !== e_v || od !== e_d || (e_v && ovc !== e_vc) || (i == 2 && ov !== 1'b1)) begin
        n_errors++;
        $display("FAIL pause_data cyc %0d: valid=%b vc=%b data=%h want %b %b %h",
                 i, ov, ovc, od, e_v, e_vc, e_d);
      end
    end
    pse = 1'b0;
  endtask

  task automatic test_urgency();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    logic [1:0] want_g[7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    reset_dut();
    fill(20, 20);
    for (int i = 0; i < 7; i++) begin
      af1 = (i >= 2 && i < 6);
      tick(og, ov, ovc, od);
      n_checks++;
      if (og !== want_g[i] || og !== e_g) begin
        n_errors++;
        $display("FAIL urgent_grant cyc %0d: read=%b want %b (model %b)", i, og, want_g[i], e_g);
      end
    end
    af1 = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    logic [1:0] want_g[9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    reset_dut();
    fill(20, 20);
    for (int i = 0; i < 3; i++) tick(og, ov, ovc, od);
    #1;
    n_checks++;
    if (valid_out !== 1'b1) begin
      n_errors++; $display("FAIL midrst_before: valid=%b want 1", valid_out);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || {read1, read0} !== 2'b00) begin
      n_errors++;
      $display("FAIL midrst_clear: valid=%b data=%h read=%b want 0 00 00",
               valid_out, data_out, {read1, read0});
    end
    @(posedge clk);
    #1;
    model_reset();
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(og, ov, ovc, od);
      n_checks++;
      if (og !== want_g[i] || og !== e_g) begin
        n_errors++;
        $display("FAIL midrst_grant cyc %0d: read=%b want %b (model %b)", i, og, want_g[i], e_g);
      end
      n_checks++;
      if (ov !== e_v || od !== e_d || (e_v && ovc !== e_vc) || (i == 0 && ov !== 1'b0)) begin
        n_errors++;
        $display("FAIL midrst_data cyc %0d: valid=%b vc=%b data=%h want %b %b %h",
                 i, ov, ovc, od, e_v, e_vc, e_d);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] og; logic ov, ovc; logic [7:0] od;
    reset_dut();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 45 && q0.size() < 8) q0.push_back(8'($urandom));
      if ($urandom_range(0, 99) < 40 && q1.size() < 8) q1.push_back(8'($urandom));
      af0 = ($urandom_range(0, 99) < 20);
      af1 = ($urandom_range(0, 99) < 20);
      pse = ($urandom_range(0, 99) < 15);
      tick(og, ov, ovc, od);
      n_checks++;
      if (og !== e_g) begin
        n_errors++; $display("FAIL rand_grant cyc %0d: read=%b want %b", i, og, e_g);
      end
      n_checks++;
      if (ov !== e_v || od !== e_d || (e_v && ovc !== e_vc)) begin
        n_errors++;
        $display("FAIL rand_data cyc %0d: valid=%b vc=%b data=%h want %b %b %h",
                 i, ov, ovc, od, e_v, e_vc, e_d);
      end
    end
    pse = 1'b0; af0 = 1'b0; af1 = 1'b0;
  endtask

  initial begin
    out0 = 8'h00; out1 = 8'h00;
    test_reset();
    test_single_vc();
    test_fairness();
    test_pause();
    test_urgency();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
